duty_selector_multi: RTL and testbench
======================================

Name: duty_selector_multi

Overview:
Multi-channel duty/value selector for the PWM datapath. Holds N_CH independent SIZE_COUNT-bit setpoints, each adjusted by up/down push-buttons with a configurable step, min/max limits and a wrap or saturate mode. Adds press-edge detection and hold-to-auto-repeat, plus a direct load path. Sits between the debounced button inputs and the PWM comparators, one setpoint per PWM channel.

Parameters:
SIZE_COUNT, 8, setpoint width in bits
N_CH, 4, number of channels (>=1)
STEP, 1, increment/decrement amount (1..MAX_VAL-MIN_VAL)
MIN_VAL, 0, lowest legal setpoint
MAX_VAL, 2**SIZE_COUNT-1, highest legal setpoint (> MIN_VAL)
WRAP, 1, 1 = wrap at limits, 0 = saturate
HOLD_CYCLES, 50_000_000, cycles a button is held before auto-repeat starts
REPEAT_CYCLES, 5_000_000, cycles between auto-repeat steps

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
ena  in  1  step enable; low freezes stepping
sum  in  1  increment button, active-low, debounced and synchronous to clk upstream
rest  in  1  decrement button, active-low, debounced and synchronous to clk upstream
ch_sel  in  max(1,$clog2(N_CH))  channel targeted by buttons and load
load  in  1  load strobe, active-high
load_val  in  SIZE_COUNT  value to load
valor  out  N_CH*SIZE_COUNT  all setpoints, channel k at [k*SIZE_COUNT +: SIZE_COUNT]
changed  out  1  one-cycle pulse: a setpoint changed value
at_max  out  1  selected channel == MAX_VAL
at_min  out  1  selected channel == MIN_VAL

Behaviour:
- Reset (rst=1 at clk edge): all setpoints = MIN_VAL, changed=0, FSM = IDLE, timer = 0. The edge-detect registers reset to "pressed", so a button held through reset is ignored until released.
- at_max and at_min are combinational from valor[ch_sel].
- Press edge: a button's previous sample is 1 and its current sample is 0.
- FSM states:
  - IDLE: on a sum or rest press edge with ena=1 and the other button released, step the channel given by ch_sel. Latch the direction and channel, clear the timer, go to HOLD.
  - HOLD: the timer counts each cycle. When timer == HOLD_CYCLES-1 and the button is still held, step, clear the timer and go to REPEAT.
  - REPEAT: when timer == REPEAT_CYCLES-1, step and clear the timer.
  - From HOLD or REPEAT, go to IDLE without stepping if the latched button is released, the other button is pressed, ena=0, or ch_sel differs from the latched channel.
- Both buttons pressed in the same cycle: no step; the FSM stays in, or returns to, IDLE.
- Step timing: the new value is visible on valor the cycle after the triggering edge. With HOLD=8 and REPEAT=4, steps land at press edge t0, then t0+8, t0+12, t0+16, and so on.
- Up step, non-wrapping case: if v > MAX_VAL-STEP, the result is MIN_VAL when WRAP=1, else MAX_VAL. Otherwise v+STEP.
- Down step, non-wrapping case: if v < MIN_VAL+STEP, the result is MAX_VAL when WRAP=1, else MIN_VAL. Otherwise v-STEP.
- Step arithmetic is computed one bit wider than SIZE_COUNT, so there is no intermediate overflow.
- Load: load=1 writes clamp(load_val, MIN_VAL, MAX_VAL) to valor[ch_sel], independent of ena.
  - Load has priority over a same-cycle step on the same channel; that step is dropped, but the FSM still advances.
  - A same-cycle step on another channel is still applied.
- ena=0: no steps, FSM forced to IDLE, setpoints held.
- changed: high for exactly one cycle, aligned with the cycle the new value appears on valor. Only asserted if some setpoint's value actually differs; saturating at a limit or loading an equal value gives no pulse.
- Non-selected channels never change.

Decomposition:
- Package duty_sel_pkg holds:
  - the state enum {IDLE, HOLD, REPEAT};
  - the timer width function (clog2 of max(HOLD_CYCLES, REPEAT_CYCLES));
  - the WRAP mode constants;
  - a clamp function.
- Sub-module key_repeat contains the edge detect, FSM and timer. It outputs step_up and step_dn pulses plus the latched channel.
- duty_selector_multi contains the setpoint register array, step/limit arithmetic, load, changed, at_max and at_min.

Test Plan:
- Use defaults except HOLD_CYCLES=8 and REPEAT_CYCLES=4.
- Reset, then a single sum tap (low 3 cycles) on ch 0 -> ch0 = 1, one changed pulse, ch1..3 = 0.
- WRAP=1: load 255 to ch2, then one sum tap -> ch2 = 0. Then one rest tap -> ch2 = 255.
- WRAP=0, STEP=10, MIN=20, MAX=200: load 195, sum tap -> 200 with changed. Second tap -> 200, no changed. Load 5 -> 20.
- Hold rest low 20 cycles on ch1 preloaded with 100 -> steps at t0, t0+8, t0+12, t0+16, final 96. Release -> no further steps.
- Both buttons low together, a button held through reset, ena=0 during a hold -> no steps at all.
- Switch ch_sel mid-hold -> repeat stops.
- load on ch3 coincident with a sum edge on ch3 -> ch3 = load_val.

Source files
------------

// File: rtl/duty_sel_pkg.sv
// Shared types, constants and helper functions for the duty/value selector.
package duty_sel_pkg;

  // Button repeat FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  // Limit behaviour selectors for the WRAP parameter.
  localparam int WRAP_ON  = 1;
  localparam int WRAP_SAT = 0;

  // Width of a timer that must reach max(hold, repeat) - 1; never below 1 bit.
  function automatic int timer_width(input int hold_cycles, input int repeat_cycles);
    int m;
    m = (hold_cycles > repeat_cycles) ? hold_cycles : repeat_cycles;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  // Clamp v into [lo, hi].
  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/key_repeat.sv
// Press-edge detection plus hold-to-auto-repeat for an up/down button pair.
module key_repeat
  import duty_sel_pkg::*;
#(
  parameter int HOLD_CYCLES   = 8,
  parameter int REPEAT_CYCLES = 4,
  parameter int CH_W          = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ena,
  input  logic            sum,
  input  logic            rest,
  input  logic [CH_W-1:0] ch_sel,
  output logic            step_up,
  output logic            step_dn,
  output logic [CH_W-1:0] step_ch
);

  localparam int TW = timer_width(HOLD_CYCLES, REPEAT_CYCLES);
  localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_CYCLES - 1);

  state_t          state_reg, state_next;
  logic [TW-1:0]   timer_reg, timer_next;
  logic            dir_up_reg, dir_up_next;
  logic [CH_W-1:0] ch_lat_reg, ch_lat_next;
  logic            sum_prev_reg, rest_prev_reg;

  // Buttons are active-low; a press edge is a 1 -> 0 transition.
  logic sum_held, rest_held, sum_press, rest_press;
  logic btn_held, other_held;
  assign sum_held   = ~sum;
  assign rest_held  = ~rest;
  assign sum_press  = sum_prev_reg & ~sum;
  assign rest_press = rest_prev_reg & ~rest;
  assign btn_held   = dir_up_reg ? sum_held : rest_held;
  assign other_held = dir_up_reg ? rest_held : sum_held;

  // While stepping from IDLE the live selection is the target; afterwards the latched one.
  assign step_ch = (state_reg == IDLE) ? ch_sel : ch_lat_reg;

  // State, timer and edge-detect registers; previous samples reset to "pressed"
  // so a button held through reset needs a release before it counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      timer_reg     <= '0;
      dir_up_reg    <= 1'b0;
      ch_lat_reg    <= '0;
      sum_prev_reg  <= 1'b0;
      rest_prev_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      dir_up_reg    <= dir_up_next;
      ch_lat_reg    <= ch_lat_next;
      sum_prev_reg  <= sum;
      rest_prev_reg <= rest;
    end
  end

  // Next-state logic and step pulses.
  always_comb begin
    state_next  = state_reg;
    timer_next  = timer_reg + TW'(1);
    dir_up_next = dir_up_reg;
    ch_lat_next = ch_lat_reg;
    step_up     = 1'b0;
    step_dn     = 1'b0;
    case (state_reg)
      IDLE: begin
        timer_next = '0;
        if (ena && sum_press && !rest_held) begin
          step_up     = 1'b1;
          dir_up_next = 1'b1;
          ch_lat_next = ch_sel;
          state_next  = HOLD;
        end else if (ena && rest_press && !sum_held) begin
          step_dn     = 1'b1;
          dir_up_next = 1'b0;
          ch_lat_next = ch_sel;
          state_next  = HOLD;
        end
      end
      HOLD, REPEAT: begin
        if (!btn_held || other_held || !ena || (ch_sel != ch_lat_reg)) begin
          state_next = IDLE;
          timer_next = '0;
        end else if ((state_reg == HOLD && timer_reg == HOLD_LAST) ||
                     (state_reg == REPEAT && timer_reg == REPEAT_LAST)) begin
          step_up    = dir_up_reg;
          step_dn    = ~dir_up_reg;
          timer_next = '0;
          state_next = REPEAT;
        end
      end
      default: begin
        state_next = IDLE;
        timer_next = '0;
      end
    endcase
  end

endmodule

// File: rtl/duty_selector_multi.sv
// Multi-channel setpoint selector: button stepping with limits, direct load, change flag.
module duty_selector_multi
  import duty_sel_pkg::*;
#(
  parameter int SIZE_COUNT    = 8,
  parameter int N_CH          = 4,
  parameter int STEP          = 1,
  parameter int MIN_VAL       = 0,
  parameter int MAX_VAL       = 2**SIZE_COUNT - 1,
  parameter int WRAP          = WRAP_ON,
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 5_000_000
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     ena,
  input  logic                                     sum,
  input  logic                                     rest,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] ch_sel,
  input  logic                                     load,
  input  logic [SIZE_COUNT-1:0]                    load_val,
  output logic [N_CH*SIZE_COUNT-1:0]               valor,
  output logic                                     changed,
  output logic                                     at_max,
  output logic                                     at_min
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int W    = SIZE_COUNT + 1;
  localparam logic [W-1:0] MAX_W  = W'(MAX_VAL);
  localparam logic [W-1:0] MIN_W  = W'(MIN_VAL);
  localparam logic [W-1:0] STEP_W = W'(STEP);
  localparam logic [SIZE_COUNT-1:0] MAX_S = SIZE_COUNT'(MAX_VAL);
  localparam logic [SIZE_COUNT-1:0] MIN_S = SIZE_COUNT'(MIN_VAL);

  logic [SIZE_COUNT-1:0] val_reg  [N_CH];
  logic [SIZE_COUNT-1:0] val_next [N_CH];
  logic [N_CH-1:0]       diff;
  logic                  changed_reg;

  logic                  step_up, step_dn;
  logic [CH_W-1:0]       step_ch;
  logic [W-1:0]          cur_w;
  logic [SIZE_COUNT-1:0] step_val;
  logic [SIZE_COUNT-1:0] load_clamped;

  key_repeat #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES),
    .CH_W         (CH_W)
  ) u_key (
    .clk    (clk),
    .rst    (rst),
    .ena    (ena),
    .sum    (sum),
    .rest   (rest),
    .ch_sel (ch_sel),
    .step_up(step_up),
    .step_dn(step_dn),
    .step_ch(step_ch)
  );

  assign cur_w        = {1'b0, val_reg[step_ch]};
  assign load_clamped = SIZE_COUNT'(clamp(int'(load_val), MIN_VAL, MAX_VAL));

  // One shared step unit on the targeted channel, computed a bit wider to avoid overflow.
  always_comb begin
    step_val = val_reg[step_ch];
    if (step_up) begin
      if (cur_w > MAX_W - STEP_W) step_val = (WRAP == WRAP_ON) ? MIN_S : MAX_S;
      else                        step_val = SIZE_COUNT'(cur_w + STEP_W);
    end else if (step_dn) begin
      if (cur_w < MIN_W + STEP_W) step_val = (WRAP == WRAP_ON) ? MAX_S : MIN_S;
      else                        step_val = SIZE_COUNT'(cur_w - STEP_W);
    end
  end

  // Per-channel next value: load beats a step aimed at the same channel.
  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic load_hit, step_hit;
      assign load_hit     = load && (ch_sel == CH_W'(gi));
      assign step_hit     = (step_up || step_dn) && (step_ch == CH_W'(gi));
      assign val_next[gi] = load_hit ? load_clamped :
                            step_hit ? step_val : val_reg[gi];
      assign diff[gi]     = (val_next[gi] != val_reg[gi]);
      assign valor[gi*SIZE_COUNT +: SIZE_COUNT] = val_reg[gi];
    end
  endgenerate

  // Setpoint array and the change pulse that accompanies each real update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) val_reg[i] <= MIN_S;
      changed_reg <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) val_reg[i] <= val_next[i];
      changed_reg <= |diff;
    end
  end

  assign changed = changed_reg;
  assign at_max  = (val_reg[ch_sel] == MAX_S);
  assign at_min  = (val_reg[ch_sel] == MIN_S);

endmodule

// File: tb/tb_duty_selector_multi.sv
// Directed bench: wrapping unit (A) and saturating STEP=10 unit (B), short hold timers.
module tb_duty_selector_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ena;
  logic        sum_a, rest_a, load_a, changed_a, at_max_a, at_min_a;
  logic [1:0]  ch_a;
  logic [7:0]  lv_a;
  logic [31:0] valor_a;
  logic        sum_b, rest_b, load_b, changed_b, at_max_b, at_min_b;
  logic [1:0]  ch_b;
  logic [7:0]  lv_b;
  logic [31:0] valor_b;

  duty_selector_multi #(.HOLD_CYCLES(8), .REPEAT_CYCLES(4)) dut_a (
    .clk(clk), .rst(rst), .ena(ena), .sum(sum_a), .rest(rest_a), .ch_sel(ch_a),
    .load(load_a), .load_val(lv_a), .valor(valor_a), .changed(changed_a),
    .at_max(at_max_a), .at_min(at_min_a)
  );

  duty_selector_multi #(.STEP(10), .MIN_VAL(20), .MAX_VAL(200), .WRAP(0),
                        .HOLD_CYCLES(8), .REPEAT_CYCLES(4)) dut_b (
    .clk(clk), .rst(rst), .ena(ena), .sum(sum_b), .rest(rest_b), .ch_sel(ch_b),
    .load(load_b), .load_val(lv_b), .valor(valor_b), .changed(changed_b),
    .at_max(at_max_b), .at_min(at_min_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int chg_a    = 0;
  int chg_b    = 0;
  int ev_q[$];
  logic [31:0] prev_a = '0;

  always @(posedge clk) cyc++;

  // Count change pulses and record the cycle of every valor_a update.
  always @(negedge clk) begin
    if (changed_a) chg_a++;
    if (changed_b) chg_b++;
    if (valor_a !== prev_a) ev_q.push_back(cyc);
    prev_a = valor_a;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  function automatic int va(input int k);
    return int'(valor_a[k*8 +: 8]);
  endfunction

  function automatic int vb(input int k);
    return int'(valor_b[k*8 +: 8]);
  endfunction

  task automatic tap_a(input bit up);
    if (up) sum_a = 1'b0; else rest_a = 1'b0;
    tick(3);
    sum_a = 1'b1; rest_a = 1'b1;
    tick(2);
  endtask

  task automatic tap_b(input bit up);
    if (up) sum_b = 1'b0; else rest_b = 1'b0;
    tick(3);
    sum_b = 1'b1; rest_b = 1'b1;
    tick(2);
  endtask

  task automatic load_a_t(input int ch, input int v);
    ch_a = 2'(ch); lv_a = 8'(v); load_a = 1'b1;
    tick();
    load_a = 1'b0;
    tick();
  endtask

  task automatic load_b_t(input int ch, input int v);
    ch_b = 2'(ch); lv_b = 8'(v); load_b = 1'b1;
    tick();
    load_b = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1;
    sum_a = 1'b1; rest_a = 1'b1; load_a = 1'b0; ch_a = 2'd0; lv_a = '0;
    sum_b = 1'b1; rest_b = 1'b1; load_b = 1'b0; ch_b = 2'd0; lv_b = '0;
    tick(3);
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_valor_a", int'(valor_a), 0);
    check("rst_at_min_a", int'(at_min_a), 1);
    check("rst_at_max_a", int'(at_max_a), 0);
    check("rst_changed_a", int'(changed_a), 0);
    check("rst_valor_b", int'(valor_b), int'(32'h14141414));

    // Single up tap on ch0
    chg_a = 0;
    tap_a(1'b1);
    check("tap_ch0", va(0), 1);
    check("tap_changed", chg_a, 1);
    check("tap_others", int'(valor_a[31:8]), 0);

    // Wrap at both limits on ch2
    load_a_t(2, 255);
    check("ld255_at_max", int'(at_max_a), 1);
    chg_a = 0;
    tap_a(1'b1);
    check("wrap_up", va(2), 0);
    check("wrap_up_changed", chg_a, 1);
    check("wrap_up_at_min", int'(at_min_a), 1);
    tap_a(1'b0);
    check("wrap_dn", va(2), 255);

    // Saturating unit: STEP=10, limits 20..200
    load_b_t(0, 195);
    check("sat_ld195", vb(0), 195);
    chg_b = 0;
    tap_b(1'b1);
    check("sat_up", vb(0), 200);
    check("sat_up_changed", chg_b, 1);
    check("sat_at_max", int'(at_max_b), 1);
    chg_b = 0;
    tap_b(1'b1);
    check("sat_hold", vb(0), 200);
    check("sat_no_changed", chg_b, 0);
    load_b_t(0, 5);
    check("sat_ld_clamp", vb(0), 20);
    check("sat_at_min", int'(at_min_b), 1);

    // Hold rest for 20 cycles on ch1 from 100
    load_a_t(1, 100);
    ev_q.delete();
    chg_a = 0;
    rest_a = 1'b0;
    tick(20);
    rest_a = 1'b1;
    tick(10);
    check("hold_steps", ev_q.size(), 4);
    if (ev_q.size() == 4) begin
      check("hold_t8", ev_q[1] - ev_q[0], 8);
      check("hold_t12", ev_q[2] - ev_q[0], 12);
      check("hold_t16", ev_q[3] - ev_q[0], 16);
    end
    check("hold_final", va(1), 96);
    check("hold_changed", chg_a, 4);

    // Both buttons pressed together
    ch_a = 2'd0;
    tick();
    ev_q.delete();
    sum_a = 1'b0; rest_a = 1'b0;
    tick(12);
    sum_a = 1'b1; rest_a = 1'b1;
    tick(2);
    check("both_no_step", ev_q.size(), 0);
    check("both_ch0", va(0), 1);

    // ena dropped during a hold: only the press step lands
    ev_q.delete();
    sum_a = 1'b0;
    tick(3);
    ena = 1'b0;
    tick(12);
    ena = 1'b1;
    tick(3);
    sum_a = 1'b1;
    tick(2);
    check("ena_steps", ev_q.size(), 1);
    check("ena_ch0", va(0), 2);

    // Channel switch mid-hold stops repeat
    ev_q.delete();
    sum_a = 1'b0;
    tick(4);
    ch_a = 2'd1;
    tick(16);
    sum_a = 1'b1;
    tick(2);
    check("sw_steps", ev_q.size(), 1);
    check("sw_ch0", va(0), 3);
    check("sw_ch1", va(1), 96);

    // Load coincident with an up press on ch3
    ch_a = 2'd3; lv_a = 8'd77; load_a = 1'b1; sum_a = 1'b0;
    tick();
    load_a = 1'b0;
    tick(2);
    sum_a = 1'b1;
    tick(2);
    check("ld_prio_ch3", va(3), 77);

    // Button held through reset is ignored until released
    ch_a = 2'd0;
    sum_a = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick();
    ev_q.delete();
    tick(12);
    check("rst_held_steps", ev_q.size(), 0);
    check("rst_held_valor", int'(valor_a), 0);
    sum_a = 1'b1;
    tick(2);
    tap_a(1'b1);
    check("post_rst_tap", va(0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
